// File: rtl/line_buffer_pkg.sv
// Shared types for the line buffer sequencer: FSM state encoding and the
// helper that sizes physical line indices.
package line_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PRIME,
    STREAM,
    DONE
  } lbc_state_t;

  function automatic int line_idx_w(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

endpackage

// File: rtl/lbc_raster_counter.sv
// Column/row position of the next accepted pixel within the frame, with
// end-of-line and end-of-frame flags for the pixel at the current position.
module lbc_raster_counter #(
  parameter int ADDR_WIDTH = 14,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  adv,
  output logic [ADDR_WIDTH-1:0] col,
  output logic [15:0]           row,
  output logic                  eol,
  output logic                  eof
);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [15:0]           ROW_LAST = 16'(IMG_HEIGHT - 1);

  assign eol = (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (eol) begin
        col <= '0;
        row <= row + 16'd1;
      end else begin
        col <= col + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer sequencer: drives buffer writes/rotation and flags full windows.
// Optional LBC_STATS_EN adds stall_cnt and frame_cnt outputs.
//   state  | meaning
//   IDLE   | waiting for start
//   SYNC   | one lb_eol to realign buffer read address and rotate line
//   PRIME  | filling rows 0..KERNEL_SIZE-2, no windows
//   STREAM | filling remaining rows, one window column per accept
//   DONE   | frame_done pulse
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_LINES   = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  output logic                               s_ready,
  input  logic                               m_ready,
  output logic                               lb_we,
  output logic [ADDR_WIDTH-1:0]              lb_wr_addr,
  output logic [DATA_WIDTH-1:0]              lb_data,
  output logic                               lb_eol,
  output logic                               lb_rd_adv,
  output logic                               win_valid,
  output logic [DATA_WIDTH-1:0]              win_px,
  output logic [line_idx_w(NUM_LINES)-1:0]   win_base,
  output logic [ADDR_WIDTH-1:0]              win_col,
  output logic [15:0]                        win_row,
  output logic                               busy,
  output logic                               frame_done
`ifdef LBC_STATS_EN
  ,
  output logic [31:0]                        stall_cnt,
  output logic [15:0]                        frame_cnt
`endif
);

  localparam int LINE_W = line_idx_w(NUM_LINES);
  localparam int BACK   = (KERNEL_SIZE - 1) % NUM_LINES;
  localparam logic [15:0] PRIME_LAST_ROW = 16'(KERNEL_SIZE - 2);

  if (NUM_LINES < KERNEL_SIZE) begin : g_chk_lines
    $error("line_buffer_ctrl: NUM_LINES must be >= KERNEL_SIZE");
  end
  if (IMG_WIDTH > 16384 || IMG_WIDTH > (1 << ADDR_WIDTH)) begin : g_chk_width
    $error("line_buffer_ctrl: IMG_WIDTH exceeds 16384 or ADDR_WIDTH range");
  end
  if (IMG_HEIGHT == KERNEL_SIZE - 1) begin : g_chk_height
    $error("line_buffer_ctrl: IMG_HEIGHT must not equal KERNEL_SIZE-1");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_chk_data
    $error("line_buffer_ctrl: DATA_WIDTH must be 8..32");
  end

  lbc_state_t state, state_nxt;
  logic       active;
  logic       acc;
  logic       in_stream;
  logic [ADDR_WIDTH-1:0] col;
  logic [15:0]           row;
  logic                  eol;
  logic                  eof;
  logic [LINE_W-1:0]     wr_line;
  logic [LINE_W-1:0]     oldest_line;

  assign active    = (state == PRIME) || (state == STREAM);
  assign in_stream = (state == STREAM);
  assign acc       = s_valid && active && m_ready;

  lbc_raster_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .clr   (state == SYNC),
    .adv   (acc),
    .col   (col),
    .row   (row),
    .eol   (eol),
    .eof   (eof)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SYNC;
      SYNC:    state_nxt = (KERNEL_SIZE > 1) ? PRIME : STREAM;
      PRIME:   if (acc && eol && (row == PRIME_LAST_ROW)) state_nxt = STREAM;
      STREAM:  if (acc && eof) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = active && m_ready;
    lb_we      = acc;
    lb_rd_adv  = acc;
    lb_wr_addr = col;
    lb_data    = acc ? s_data : '0;
    lb_eol     = (state == SYNC) || (acc && eol);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  // Mirrors the buffer's own unreset write-line pointer, so no reset here.
  always_ff @(posedge clk) begin
    if (lb_eol) begin
      wr_line <= (wr_line == LINE_W'(NUM_LINES - 1)) ? '0 : wr_line + LINE_W'(1);
    end
  end

  assign oldest_line = LINE_W'((int'(wr_line) + NUM_LINES - BACK) % NUM_LINES);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_px    <= '0;
      win_base  <= '0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= acc && in_stream;
      if (acc && in_stream) begin
        win_px   <= s_data;
        win_base <= oldest_line;
        win_col  <= col;
        win_row  <= row;
      end
    end
  end

`ifdef LBC_STATS_EN
  logic stall_now;
  assign stall_now = active && s_valid && !s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (stall_now && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (frame_done && (frame_cnt != '1)) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized scoreboard bench for line_buffer_ctrl (8x6 image, 3-row kernel,
// 4 physical lines); stats ports are exercised when LBC_STATS_EN is defined.
module tb_line_buffer_ctrl;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int KS = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int AW = 14;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          reset, start, s_valid, m_ready;
  logic [DW-1:0] s_data;
  logic          s_ready, lb_we, lb_eol, lb_rd_adv, win_valid, busy, frame_done;
  logic [AW-1:0] lb_wr_addr, win_col;
  logic [DW-1:0] lb_data, win_px;
  logic [1:0]    win_base;
  logic [15:0]   win_row;
`ifdef LBC_STATS_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   frame_cnt;
`endif

  line_buffer_ctrl #(
    .DATA_WIDTH (DW), .NUM_LINES (NL), .KERNEL_SIZE (KS),
    .IMG_WIDTH (IW), .IMG_HEIGHT (IH), .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
    .m_ready (m_ready), .lb_we (lb_we), .lb_wr_addr (lb_wr_addr),
    .lb_data (lb_data), .lb_eol (lb_eol), .lb_rd_adv (lb_rd_adv),
    .win_valid (win_valid), .win_px (win_px), .win_base (win_base),
    .win_col (win_col), .win_row (win_row), .busy (busy),
    .frame_done (frame_done)
`ifdef LBC_STATS_EN
    , .stall_cnt (stall_cnt), .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] col;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [DW-1:0] px;
    logic [AW-1:0] col;
    logic [15:0]   row;
    logic [1:0]    base;
    int            cyc;
  } win_t;

  wr_t  wr_q[$];
  win_t win_q[$];
  int   done_q[$];
  wr_t  m_wr;
  win_t m_win;
  int   m_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame phase, pixels accepted, physical line per row.
  int ph  = 0;     // 0 idle, 1 sync, 2 accepting, 3 done
  int k   = 0;
  int ptr = 0;
  int row_line[IH];
  int m_stall  = 0;
  int m_frames = 0;

  logic chk_en = 1'b0;
  logic exp_busy = 1'b0, exp_s_ready = 1'b0, exp_we = 1'b0, exp_eol = 1'b0, exp_act = 1'b0;
  int   exp_col = 0;
  int   eol_seen = 0;
  int   win_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT event with no expected entry (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("s_ready", s_ready, exp_s_ready);
      chk("lb_we", lb_we, exp_we);
      chk("lb_rd_adv", lb_rd_adv, exp_we);
      chk("lb_eol", lb_eol, exp_eol);
      if (lb_eol) eol_seen++;
      if (exp_act && !lb_we) chk("wr_addr_hold", lb_wr_addr, exp_col);
      if (lb_we) begin
        if (wr_q.size() == 0) miss("write");
        else begin
          m_wr = wr_q.pop_front();
          chk("wr_cycle", cyc, m_wr.cyc);
          chk("wr_addr", lb_wr_addr, m_wr.col);
          chk("wr_data", lb_data, m_wr.data);
        end
      end
      if (win_valid) begin
        win_seen++;
        if (win_q.size() == 0) miss("window");
        else begin
          m_win = win_q.pop_front();
          chk("win_cycle", cyc, m_win.cyc);
          chk("win_px", win_px, m_win.px);
          chk("win_col", win_col, m_win.col);
          chk("win_row", win_row, m_win.row);
          chk("win_base", win_base, m_win.base);
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) miss("frame_done");
        else begin
          m_done = done_q.pop_front();
          chk("done_cycle", cyc, m_done);
        end
      end
    end
  end

  task automatic step(input logic v, input logic mr, input logic st, input logic rs);
    logic a;
    int   col, row;
    start   = st;
    reset   = rs;
    s_valid = v;
    m_ready = mr;
    s_data  = DW'($urandom);
    a   = (ph == 2) && v && mr;
    col = k % IW;
    row = k / IW;
    exp_busy    = (ph != 0);
    exp_s_ready = (ph == 2) && mr;
    exp_we      = a;
    exp_act     = (ph == 2);
    exp_col     = col;
    exp_eol     = (ph == 1) || (a && (col == IW - 1));
    if ((ph == 2) && v && !mr) m_stall++;
    if (a) begin
      if (col == 0) row_line[row] = ptr;
      wr_q.push_back('{AW'(col), s_data, cyc});
      if (row >= KS - 1)
        win_q.push_back('{s_data, AW'(col), 16'(row), 2'(row_line[row - (KS - 1)]), cyc + 1});
      if (k + 1 == NPIX) done_q.push_back(cyc + 1);
    end
    if (exp_eol) ptr = (ptr + 1) % NL;
    @(posedge clk);
    #1;
    if (rs) begin
      ph = 0;
      m_stall = 0;
      m_frames = 0;
    end else begin
      case (ph)
        0: if (st) begin ph = 1; k = 0; end
        1: ph = 2;
        2: if (a) begin k++; if (k == NPIX) ph = 3; end
        default: begin ph = 0; m_frames++; end
      endcase
    end
  endtask

  // mode 0: back-to-back; mode 1: random valid/ready. Negative k selectors disable.
  task automatic run_frame(input int mode, input int stall_at, input int stall_len,
                           input int abort_at, input int glitch_at);
    int budget;
    int stalls;
    logic v, mr, st, rs;
    budget = 0;
    stalls = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    while (ph != 0 && budget < 2000) begin
      v  = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mr = (mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
      st = (ph == 2) && (k == glitch_at);
      rs = 1'b0;
      if ((ph == 2) && (k == stall_at) && (stalls < stall_len)) begin
        v = 1'b1; mr = 1'b0; stalls++;
      end
      if ((ph == 2) && (k == abort_at)) begin
        v = 1'b0; rs = 1'b1;
      end
      step(v, mr, st, rs);
      budget++;
    end
    if (budget >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: still busy after %0d cycles", budget);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("win_q_drained", win_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
`ifdef LBC_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("frame_cnt", frame_cnt, m_frames);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_addr", lb_wr_addr, 0);
    chk("rst_win_base", win_base, 0);
    chk("rst_win_row", win_row, 0);

    // Frame 1: back-to-back from power-on.
    eol_seen = 0; win_seen = 0;
    run_frame(0, -1, 0, -1, -1);
    chk("f1_eol_count", eol_seen, 7);
    chk("f1_win_count", win_seen, 32);
    chk("f1_busy_after", busy, 0);

    // Clear stats, then a frame with a 5-cycle m_ready stall at row3 col4.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(0, 3 * IW + 4, 5, -1, -1);

    // Random frame aborted by reset at row3 col4, then recovery frames.
    run_frame(1, -1, 0, 3 * IW + 4, -1);
    run_frame(1, -1, 0, -1, 3 * IW + 2);
    for (int f = 0; f < 3; f++)
      run_frame(1, $urandom_range(0, NPIX - 1), $urandom_range(1, 4), -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
